// File: rtl/u409_bus_timeout_pkg.sv
// ---------------------------------------------------------------------------
// u409_pkg
// Shared definitions for the U409 local-bus watchdog:
//   - bus_to_state_t : watchdog FSM states (IDLE / COUNT / TERM)
//   - DEF_*          : default parameter values (timeouts in CLK40 cycles)
//   - SEL_*          : TIMEOUT_SEL encodings
// ---------------------------------------------------------------------------
package u409_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      TERM  = 2'd2
   } bus_to_state_t;

   localparam int DEF_CNT_W    = 8;
   localparam int DEF_NUM_EXCL = 2;
   localparam int DEF_TIMEOUT0 = 125;   // ~3.1us at 40MHz
   localparam int DEF_TIMEOUT1 = 60;
   localparam int DEF_TIMEOUT2 = 200;
   localparam int DEF_TIMEOUT3 = 250;
   localparam int DEF_STAT_W   = 8;

   localparam logic [1:0] SEL_T0 = 2'd0;
   localparam logic [1:0] SEL_T1 = 2'd1;
   localparam logic [1:0] SEL_T2 = 2'd2;
   localparam logic [1:0] SEL_T3 = 2'd3;

endpackage

// File: rtl/u409_bus_timeout_chk.sv
// ---------------------------------------------------------------------------
// u409_bus_timeout_chk
// Elaboration-time parameter checker: every selectable timeout must be
// representable in the CNT_W-bit cycle counter, so the counter can never wrap
// before reaching its limit. No ports.
// ---------------------------------------------------------------------------
module u409_bus_timeout_chk
   import u409_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int TIMEOUT0 = DEF_TIMEOUT0,
   parameter int TIMEOUT1 = DEF_TIMEOUT1,
   parameter int TIMEOUT2 = DEF_TIMEOUT2,
   parameter int TIMEOUT3 = DEF_TIMEOUT3
);

   localparam longint CNT_MAX = (64'sd1 <<< CNT_W) - 64'sd1;

   if ((TIMEOUT0 > CNT_MAX) || (TIMEOUT1 > CNT_MAX) ||
       (TIMEOUT2 > CNT_MAX) || (TIMEOUT3 > CNT_MAX)) begin : g_limit_too_big
      $error("u409_bus_timeout: a TIMEOUTn exceeds 2**CNT_W-1");
   end

   if ((TIMEOUT0 < 1) || (TIMEOUT1 < 1) ||
       (TIMEOUT2 < 1) || (TIMEOUT3 < 1)) begin : g_limit_too_small
      $error("u409_bus_timeout: a TIMEOUTn is below 1");
   end

endmodule

// File: rtl/u409_bus_timeout_stats.sv
// ---------------------------------------------------------------------------
// u409_timeout_stats
// Sticky timeout statistics.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   hit        : a timeout terminates a cycle on this edge
//   clr        : synchronous clear (a simultaneous hit wins -> flag=1, count=1)
//   to_flag    : sticky, at least one timeout since clear
//   to_count   : timeouts since clear, saturating at 2**STAT_W-1
// ---------------------------------------------------------------------------
module u409_timeout_stats
   import u409_pkg::*;
#(
   parameter int STAT_W = DEF_STAT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hit,
   input  logic              clr,
   output logic              to_flag,
   output logic [STAT_W-1:0] to_count
);

   logic              flag_r;
   logic              flag_s;
   logic [STAT_W-1:0] count_r;
   logic [STAT_W-1:0] count_s;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      if (v == {STAT_W{1'b1}}) begin
         return v;
      end else begin
         return v + STAT_W'(1);
      end
   endfunction

   // Next statistics value: a hit outranks a clear on the same edge.
   always_comb begin
      flag_s  = flag_r;
      count_s = count_r;
      if (hit) begin
         flag_s  = 1'b1;
         count_s = clr ? STAT_W'(1) : sat_inc(count_r);
      end else if (clr) begin
         flag_s  = 1'b0;
         count_s = {STAT_W{1'b0}};
      end else begin
         flag_s  = flag_r;
         count_s = count_r;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_r  <= 1'b0;
         count_r <= {STAT_W{1'b0}};
      end else begin
         flag_r  <= flag_s;
         count_r <= count_s;
      end
   end

   assign to_flag  = flag_r;
   assign to_count = count_r;

endmodule

// File: rtl/u409_bus_timeout.sv
// ---------------------------------------------------------------------------
// u409_bus_timeout
// Bus-cycle watchdog for the 68040/060 local bus. A cycle starts on _TS
// (when no exclusion input is active); if no responder drives _TACK within
// the timeout selected at cycle start, a one-clock termination pulse is
// emitted and the sticky statistics are updated.
// Ports:
//   CLK40, DELAYED_TACK_RST : clock, asynchronous active-high reset
//   TSn, TACKn_IN           : transfer start / observed transfer ack (low)
//   EXCLUDE[NUM_EXCL]       : any bit high -> cycle owned elsewhere
//   TIMEOUT_SEL[2]          : timeout select, latched at cycle start
//   TO_CLR                  : synchronous clear of TO_FLAG / TO_COUNT
//   TO_TACK, TO_TEA         : one-clock termination pulse (routing below)
//   TO_FLAG, TO_COUNT       : sticky flag, saturating timeout count
// Build option: U409_BUS_TIMEOUT_TEA_EN defined -> pulse on TO_TEA and
// TO_TACK tied low; undefined -> pulse on TO_TACK and TO_TEA tied low.
// ---------------------------------------------------------------------------
module u409_bus_timeout
   import u409_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int NUM_EXCL = DEF_NUM_EXCL,
   parameter int TIMEOUT0 = DEF_TIMEOUT0,
   parameter int TIMEOUT1 = DEF_TIMEOUT1,
   parameter int TIMEOUT2 = DEF_TIMEOUT2,
   parameter int TIMEOUT3 = DEF_TIMEOUT3,
   parameter int STAT_W   = DEF_STAT_W
) (
   input  logic                CLK40,
   input  logic                DELAYED_TACK_RST,
   input  logic                TSn,
   input  logic                TACKn_IN,
   input  logic [NUM_EXCL-1:0] EXCLUDE,
   input  logic [1:0]          TIMEOUT_SEL,
   input  logic                TO_CLR,
   output logic                TO_TACK,
   output logic                TO_TEA,
   output logic                TO_FLAG,
   output logic [STAT_W-1:0]   TO_COUNT
);

   bus_to_state_t    state_r;
   bus_to_state_t    state_s;
   logic [CNT_W-1:0] counter_r;
   logic [CNT_W-1:0] counter_s;
   logic [CNT_W-1:0] limit_r;
   logic [CNT_W-1:0] limit_s;
   logic [CNT_W-1:0] sel_limit_s;
   logic             pulse_r;
   logic             pulse_s;
   logic             hit_s;
   logic             excl_s;
   logic             ack_s;

   u409_bus_timeout_chk #(
      .CNT_W    (CNT_W),
      .TIMEOUT0 (TIMEOUT0),
      .TIMEOUT1 (TIMEOUT1),
      .TIMEOUT2 (TIMEOUT2),
      .TIMEOUT3 (TIMEOUT3)
   ) u_chk ();

   assign excl_s = |EXCLUDE;
   assign ack_s  = ~TACKn_IN;

   // Timeout value requested by the current TIMEOUT_SEL.
   always_comb begin
      sel_limit_s = CNT_W'(TIMEOUT0);
      case (TIMEOUT_SEL)
         SEL_T0:  sel_limit_s = CNT_W'(TIMEOUT0);
         SEL_T1:  sel_limit_s = CNT_W'(TIMEOUT1);
         SEL_T2:  sel_limit_s = CNT_W'(TIMEOUT2);
         SEL_T3:  sel_limit_s = CNT_W'(TIMEOUT3);
         default: sel_limit_s = CNT_W'(TIMEOUT0);
      endcase
   end

   // Watchdog next state. Exclusion and a responder ack are tested before the
   // limit so that an ack on the limit edge wins over the timeout.
   always_comb begin
      state_s   = state_r;
      counter_s = counter_r;
      limit_s   = limit_r;
      pulse_s   = 1'b0;
      hit_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (!TSn && !excl_s) begin
               state_s   = COUNT;
               counter_s = CNT_W'(1);
               limit_s   = sel_limit_s;
            end else begin
               state_s   = IDLE;
            end
         end
         COUNT: begin
            if (excl_s || ack_s) begin
               state_s   = IDLE;
               counter_s = {CNT_W{1'b0}};
            end else if (counter_r == limit_r) begin
               state_s   = TERM;
               pulse_s   = 1'b1;
               hit_s     = 1'b1;
            end else begin
               counter_s = counter_r + CNT_W'(1);
            end
         end
         TERM: begin
            state_s   = IDLE;
            counter_s = {CNT_W{1'b0}};
         end
         default: begin
            state_s   = IDLE;
            counter_s = {CNT_W{1'b0}};
         end
      endcase
   end

   // Watchdog state, counter, latched limit and registered pulse.
   always_ff @(posedge CLK40 or posedge DELAYED_TACK_RST) begin
      if (DELAYED_TACK_RST) begin
         state_r   <= IDLE;
         counter_r <= {CNT_W{1'b0}};
         limit_r   <= CNT_W'(TIMEOUT0);
         pulse_r   <= 1'b0;
      end else begin
         state_r   <= state_s;
         counter_r <= counter_s;
         limit_r   <= limit_s;
         pulse_r   <= pulse_s;
      end
   end

   u409_timeout_stats #(
      .STAT_W (STAT_W)
   ) u_stats (
      .clk      (CLK40),
      .rst      (DELAYED_TACK_RST),
      .hit      (hit_s),
      .clr      (TO_CLR),
      .to_flag  (TO_FLAG),
      .to_count (TO_COUNT)
   );

`ifdef U409_BUS_TIMEOUT_TEA_EN
   assign TO_TEA  = pulse_r;
   assign TO_TACK = 1'b0;
`else
   assign TO_TACK = pulse_r;
   assign TO_TEA  = 1'b0;
`endif

endmodule

// File: tb/tb_u409_bus_timeout.sv
`timescale 1ns/1ps
module tb_u409_bus_timeout;

   logic       CLK40 = 1'b0;
   logic       DELAYED_TACK_RST = 1'b1;
   logic       TSn = 1'b1;
   logic       TACKn_IN = 1'b1;
   logic [1:0] EXCLUDE = 2'b00;
   logic [1:0] TIMEOUT_SEL = 2'b00;
   logic       TO_CLR = 1'b0;
   logic       TO_TACK;
   logic       TO_TEA;
   logic       TO_FLAG;
   logic [7:0] TO_COUNT;

   u409_bus_timeout dut (
      .CLK40            (CLK40),
      .DELAYED_TACK_RST (DELAYED_TACK_RST),
      .TSn              (TSn),
      .TACKn_IN         (TACKn_IN),
      .EXCLUDE          (EXCLUDE),
      .TIMEOUT_SEL      (TIMEOUT_SEL),
      .TO_CLR           (TO_CLR),
      .TO_TACK          (TO_TACK),
      .TO_TEA           (TO_TEA),
      .TO_FLAG          (TO_FLAG),
      .TO_COUNT         (TO_COUNT)
   );

   always #12.5 CLK40 = ~CLK40;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A cycle is described by its deadline edge: started at edge s with
   // timeout L, it times out at edge s+L unless aborted earlier. After a
   // timeout at edge d, the next start may happen no earlier than edge d+2.
   int ecount = 0;
   bit busy = 1'b0;
   int deadline = 0;
   int allow_from = 0;
   bit exp_pulse = 1'b0;
   bit exp_flag = 1'b0;
   int exp_cnt = 0;

   function automatic int lim_of(input logic [1:0] s);
      case (s)
         2'd0: return 125;
         2'd1: return 60;
         2'd2: return 200;
         2'd3: return 250;
         default: return 125;
      endcase
   endfunction

   always @(posedge CLK40 or posedge DELAYED_TACK_RST) begin
      if (DELAYED_TACK_RST) begin
         busy = 1'b0; exp_pulse = 1'b0; exp_flag = 1'b0; exp_cnt = 0; allow_from = 0;
      end else begin
         bit timed_out;
         ecount++;
         timed_out = 1'b0;
         exp_pulse = 1'b0;
         if (busy) begin
            if (!TACKn_IN || EXCLUDE != 2'b00) begin
               busy = 1'b0;
            end else if (ecount == deadline) begin
               busy = 1'b0;
               timed_out = 1'b1;
               allow_from = ecount + 2;
            end
         end else if (ecount >= allow_from && !TSn && EXCLUDE == 2'b00) begin
            busy = 1'b1;
            deadline = ecount + lim_of(TIMEOUT_SEL);
         end
         if (timed_out) begin
            exp_pulse = 1'b1;
            exp_flag = 1'b1;
            exp_cnt = TO_CLR ? 1 : ((exp_cnt + 1 > 255) ? 255 : exp_cnt + 1);
         end else if (TO_CLR) begin
            exp_flag = 1'b0;
            exp_cnt = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int npulse = 0;
   int pulse_edge = -1;

   always @(negedge CLK40) begin
`ifdef U409_BUS_TIMEOUT_TEA_EN
      check("to_tea", TO_TEA, exp_pulse);
      check("to_tack_low", TO_TACK, 0);
`else
      check("to_tack", TO_TACK, exp_pulse);
      check("to_tea_low", TO_TEA, 0);
`endif
      check("to_flag", TO_FLAG, exp_flag);
      check("to_count", TO_COUNT, exp_cnt);
      if (TO_TACK || TO_TEA) begin
         npulse++;
         pulse_edge = ecount;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge CLK40);
      #1;
   endtask

   // Drive TSn low for one clock; s is the edge index that samples it.
   task automatic start(input logic [1:0] sel, output int s);
      TIMEOUT_SEL = sel;
      TSn = 1'b0;
      s = ecount + 1;
      tick(1);
      TSn = 1'b1;
   endtask

   initial begin
      int s;
      tick(3);
      check("rst_count", TO_COUNT, 0);
      check("rst_flag", TO_FLAG, 0);
      DELAYED_TACK_RST = 1'b0;
      tick(2);

      // SEL=0, no ack: pulse 125 clocks after the start edge, one clock wide
      npulse = 0;
      start(2'd0, s);
      tick(130);
      check("t1_latency", pulse_edge - s, 125);
      check("t1_width", npulse, 1);
      check("t1_count", TO_COUNT, 1);

      // SEL=1, ack at clock 30: no pulse, stats unchanged
      npulse = 0;
      start(2'd1, s);
      tick(29);
      TACKn_IN = 1'b0;
      tick(1);
      TACKn_IN = 1'b1;
      tick(80);
      check("t2_no_pulse", npulse, 0);
      check("t2_count", TO_COUNT, 1);

      // TSn with EXCLUDE[1]: never starts
      npulse = 0;
      EXCLUDE = 2'b10;
      start(2'd0, s);
      EXCLUDE = 2'b00;
      tick(140);
      check("t3a_no_pulse", npulse, 0);
      // EXCLUDE[0] at clock 50 of a counted cycle aborts it
      start(2'd0, s);
      tick(49);
      EXCLUDE = 2'b01;
      tick(1);
      EXCLUDE = 2'b00;
      tick(100);
      check("t3b_no_pulse", npulse, 0);
      check("t3_count", TO_COUNT, 1);

      // SEL=1 with TSn re-asserted at clock 20: no restart, pulse at 60
      npulse = 0;
      start(2'd1, s);
      tick(19);
      TSn = 1'b0;
      tick(1);
      TSn = 1'b1;
      tick(50);
      check("t4_latency", pulse_edge - s, 60);
      check("t4_width", npulse, 1);
      check("t4_count", TO_COUNT, 2);

      // ack on the limit edge: responder wins
      npulse = 0;
      start(2'd1, s);
      tick(59);
      TACKn_IN = 1'b0;
      tick(1);
      TACKn_IN = 1'b1;
      tick(10);
      check("t4_ack_at_limit", npulse, 0);
      check("t4_ack_count", TO_COUNT, 2);

      // TO_CLR on the timeout edge: timeout wins, count restarts at 1
      start(2'd1, s);
      tick(59);
      TO_CLR = 1'b1;
      tick(1);
      TO_CLR = 1'b0;
      tick(5);
      check("t4_clr_count", TO_COUNT, 1);
      check("t4_clr_flag", TO_FLAG, 1);
      check("t4_clr_pulses", npulse, 1);

      // plain clear
      TO_CLR = 1'b1;
      tick(1);
      TO_CLR = 1'b0;
      tick(1);
      check("clr_count", TO_COUNT, 0);
      check("clr_flag", TO_FLAG, 0);

      // 260 timeouts: saturates at 255
      for (int i = 0; i < 260; i++) begin
         start(2'd1, s);
         tick(62);
      end
      check("t5_sat_count", TO_COUNT, 255);
      check("t5_sat_flag", TO_FLAG, 1);

      // reset at clock 40 of a counted cycle: everything zero at once
      start(2'd0, s);
      tick(39);
      DELAYED_TACK_RST = 1'b1;
      #1;
      check("t5_rst_count", TO_COUNT, 0);
      check("t5_rst_flag", TO_FLAG, 0);
      check("t5_rst_tack", TO_TACK, 0);
      check("t5_rst_tea", TO_TEA, 0);
      tick(2);
      DELAYED_TACK_RST = 1'b0;
      npulse = 0;
      tick(200);
      check("t5_no_restart", npulse, 0);

      // the two longer timeouts
      start(2'd2, s);
      tick(205);
      check("sel2_latency", pulse_edge - s, 200);
      start(2'd3, s);
      tick(255);
      check("sel3_latency", pulse_edge - s, 250);
      check("sel_count", TO_COUNT, 2);
      check("sel_pulses", npulse, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
